// File: rtl/bht_pkg.sv
// Shared types and helpers for the gshare branch history table.
//   bht_state_e : sweep FSM states (ST_INIT clears the table, ST_RUN serves traffic)
//   ctr_init    : weak not-taken counter value for a given counter width
//   ctr_max     : saturation ceiling for a given counter width
//   idx_hash    : table index hash (PC bits XOR history)
package bht_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bht_state_e;

  // Weak not-taken: MSB clear, all lower bits set.
  function automatic int unsigned ctr_init(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned ctr_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Callers zero-extend the PC slice and history, then truncate to IDX_W.
  function automatic logic [31:0] idx_hash(input logic [31:0] pc_bits,
                                           input logic [31:0] hist);
    return pc_bits ^ hist;
  endfunction

endpackage

// File: rtl/bht_sat_ctr.sv
// Combinational saturating up/down counter step.
//   ctr_i       : current counter value
//   take_i      : 1 = count up (taken), 0 = count down (not taken)
//   ctr_nxt_c_o : next counter value, clamped to [0, 2^CTR_WIDTH-1]
module bht_sat_ctr
  import bht_pkg::*;
#(
  parameter int unsigned CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] ctr_i,
  input  logic                 take_i,
  output logic [CTR_WIDTH-1:0] ctr_nxt_c_o
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = CTR_WIDTH'(ctr_max(CTR_WIDTH));

  // Clamp at both ends so the counter never wraps.
  always_comb begin
    ctr_nxt_c_o = ctr_i;
    if (take_i) begin
      if (ctr_i != CTR_MAX) ctr_nxt_c_o = ctr_i + CTR_WIDTH'(1);
    end else begin
      if (ctr_i != '0) ctr_nxt_c_o = ctr_i - CTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/bht_gshare.sv
// Fetch-stage branch predictor: table of saturating counters indexed by PC,
// optionally hashed with a global history register (build macro BHT_GSHARE_EN).
// The table is cleared by a one-entry-per-cycle sweep after reset.
//   CLK, RST                    : clock, synchronous active-high reset
//   READY                       : table initialised, predictions/updates honoured
//   PC_IN_PRED, SKIP_OFF_IN,
//   TAKE_OFF_IN, PRED_EN        : prediction request; PRED_EN shifts the GHR
//   TAKE_OUT, PRED_TAKEN        : predicted next PC and direction (combinational)
//   HIST_OUT                    : GHR used for this prediction
//   PC_IN_RES, HIST_IN_RES,
//   TAKE_IN, WE, MISPRED_IN     : resolved-branch update and GHR repair
// With BHT_GSHARE_EN undefined the GHR is absent, HIST_OUT is 0, and
// HIST_IN_RES, MISPRED_IN and PRED_EN have no effect.
module bht_gshare
  import bht_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned HIST_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  READY,
  input  logic [ADDR_WIDTH-1:0] PC_IN_PRED,
  input  logic [ADDR_WIDTH-1:0] SKIP_OFF_IN,
  input  logic [ADDR_WIDTH-1:0] TAKE_OFF_IN,
  input  logic                  PRED_EN,
  output logic [ADDR_WIDTH-1:0] TAKE_OUT,
  output logic                  PRED_TAKEN,
  output logic [HIST_WIDTH-1:0] HIST_OUT,
  input  logic [ADDR_WIDTH-1:0] PC_IN_RES,
  input  logic [HIST_WIDTH-1:0] HIST_IN_RES,
  input  logic                  TAKE_IN,
  input  logic                  WE,
  input  logic                  MISPRED_IN
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(ctr_init(CTR_WIDTH));
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_ENTRIES - 1);

  bht_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CTR_WIDTH-1:0] ctr_q [NUM_ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_upd_c;
  logic [IDX_W-1:0]     pidx_c, uidx_c;
  logic [HIST_WIDTH-1:0] hist_pred_c, hist_res_c;
  logic                 run_c;
  logic                 pred_taken_c;
  logic                 unused_ok;

  assign run_c = (state_q == ST_RUN);
  assign READY = run_c;

  // Sweep FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep FSM next state: walk the pointer once over the table, then run.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        if (ptr_q == PTR_LAST) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      ST_RUN:  ;
      default: state_d = ST_INIT;
    endcase
  end

`ifdef BHT_GSHARE_EN
  logic [HIST_WIDTH-1:0] ghr_q, ghr_d;

  always_ff @(posedge CLK) begin
    if (RST) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  // Misprediction repair outranks the speculative shift; shift-left form
  // also covers HIST_WIDTH == 1.
  always_comb begin
    ghr_d = ghr_q;
    if (run_c) begin
      if (WE && MISPRED_IN) begin
        ghr_d = HIST_WIDTH'(HIST_IN_RES << 1) | HIST_WIDTH'(TAKE_IN);
      end else if (PRED_EN) begin
        ghr_d = HIST_WIDTH'(ghr_q << 1) | HIST_WIDTH'(pred_taken_c);
      end
    end
  end

  assign hist_pred_c = ghr_q;
  assign hist_res_c  = HIST_IN_RES;
  assign unused_ok   = ^PC_IN_RES;
`else
  assign hist_pred_c = '0;
  assign hist_res_c  = '0;
  assign unused_ok   = ^{PC_IN_RES, HIST_IN_RES, MISPRED_IN, PRED_EN};
`endif

  // Index hashing; history is zero-extended into the index width.
  assign pidx_c = IDX_W'(idx_hash(32'(PC_IN_PRED[IDX_W-1:0]), 32'(hist_pred_c)));
  assign uidx_c = IDX_W'(idx_hash(32'(PC_IN_RES[IDX_W-1:0]),  32'(hist_res_c)));

  // Prediction path: no bypass of a same-cycle update.
  assign pred_taken_c = run_c & ctr_q[pidx_c][CTR_WIDTH-1];
  assign PRED_TAKEN   = pred_taken_c;
  assign TAKE_OUT     = PC_IN_PRED + (pred_taken_c ? TAKE_OFF_IN : SKIP_OFF_IN);
  assign HIST_OUT     = run_c ? hist_pred_c : '0;

  bht_sat_ctr #(
    .CTR_WIDTH (CTR_WIDTH)
  ) u_sat_ctr (
    .ctr_i       (ctr_q[uidx_c]),
    .take_i      (TAKE_IN),
    .ctr_nxt_c_o (ctr_upd_c)
  );

  // Counter table: sweep writes during INIT, resolved updates during RUN.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == ST_INIT) begin
        ctr_q[ptr_q] <= CTR_INIT;
      end else if (WE) begin
        ctr_q[uidx_c] <= ctr_upd_c;
      end
    end
  end

endmodule

// File: tb/tb_bht_gshare.sv
// Scoreboard bench for bht_gshare: stimulus pushes expected outputs from a
// behavioural model; a negedge monitor pops and compares.
module tb_bht_gshare;

  localparam int unsigned NUM = 16;
  localparam int unsigned AW  = 32;
  localparam int unsigned CW  = 2;
  localparam int unsigned HW  = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int CINIT = (1 << (CW - 1)) - 1;
  localparam int HMASK = (1 << HW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic          READY;
  logic [AW-1:0] PC_IN_PRED, SKIP_OFF_IN, TAKE_OFF_IN, TAKE_OUT, PC_IN_RES;
  logic          PRED_EN, PRED_TAKEN, TAKE_IN, WE, MISPRED_IN;
  logic [HW-1:0] HIST_OUT, HIST_IN_RES;

  always #5 CLK = ~CLK;

  bht_gshare #(
    .NUM_ENTRIES (NUM),
    .ADDR_WIDTH  (AW),
    .CTR_WIDTH   (CW),
    .HIST_WIDTH  (HW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .READY       (READY),
    .PC_IN_PRED  (PC_IN_PRED),
    .SKIP_OFF_IN (SKIP_OFF_IN),
    .TAKE_OFF_IN (TAKE_OFF_IN),
    .PRED_EN     (PRED_EN),
    .TAKE_OUT    (TAKE_OUT),
    .PRED_TAKEN  (PRED_TAKEN),
    .HIST_OUT    (HIST_OUT),
    .PC_IN_RES   (PC_IN_RES),
    .HIST_IN_RES (HIST_IN_RES),
    .TAKE_IN     (TAKE_IN),
    .WE          (WE),
    .MISPRED_IN  (MISPRED_IN)
  );

  typedef struct {
    logic          ready;
    logic          taken;
    logic [AW-1:0] npc;
    logic [HW-1:0] hist;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: plain integers.
  int m_ctr [NUM];
  int m_ghr;
  int m_ready;
  int m_sweep;

  function automatic int tbl_idx(input logic [AW-1:0] pc, input int hist);
`ifdef BHT_GSHARE_EN
    return (int'(pc % NUM) ^ hist) % NUM;
`else
    return int'(pc % NUM) + 0 * hist;
`endif
  endfunction

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ready", AW'(READY), AW'(e.ready));
      check("pred_taken", AW'(PRED_TAKEN), AW'(e.taken));
      check("take_out", TAKE_OUT, e.npc);
      check("hist_out", AW'(HIST_OUT), AW'(e.hist));
    end
  end

  // One clock of stimulus: drive, push expectation, advance the model.
  task automatic cyc(input logic rst, input logic [AW-1:0] pcp, input logic [AW-1:0] skip,
                     input logic [AW-1:0] toff, input logic pen, input logic [AW-1:0] pcr,
                     input logic [HW-1:0] hres, input logic tin, input logic we,
                     input logic mis);
    exp_t e;
    int   pi, ui, c;
    logic tk;
    RST = rst; PC_IN_PRED = pcp; SKIP_OFF_IN = skip; TAKE_OFF_IN = toff; PRED_EN = pen;
    PC_IN_RES = pcr; HIST_IN_RES = hres; TAKE_IN = tin; WE = we; MISPRED_IN = mis;
    tk = 1'b0;
    if (m_ready != 0) begin
      pi = tbl_idx(pcp, m_ghr);
      tk = (m_ctr[pi] >= (1 << (CW - 1)));
    end
    e.ready = (m_ready != 0);
    e.taken = tk;
    e.npc   = pcp + (tk ? toff : skip);
    e.hist  = (m_ready != 0) ? HW'(m_ghr) : '0;
    exp_q.push_back(e);
    @(posedge CLK);
    if (rst) begin
      m_ready = 0; m_sweep = NUM; m_ghr = 0;
    end else if (m_ready == 0) begin
      m_sweep--;
      if (m_sweep == 0) begin
        for (int i = 0; i < NUM; i++) m_ctr[i] = CINIT;
        m_ready = 1;
      end
    end else begin
      if (we) begin
        ui = tbl_idx(pcr, int'(hres));
        c  = m_ctr[ui];
        m_ctr[ui] = tin ? ((c < CMAX) ? c + 1 : CMAX) : ((c > 0) ? c - 1 : 0);
      end
`ifdef BHT_GSHARE_EN
      if (we && mis)  m_ghr = ((int'(hres) << 1) | int'(tin)) & HMASK;
      else if (pen)   m_ghr = ((m_ghr << 1) | int'(tk)) & HMASK;
`endif
    end
    #1;
  endtask

  task automatic rnd(input int rst_odds);
    cyc((rst_odds != 0) && ($urandom_range(0, rst_odds - 1) == 0),
        AW'($urandom_range(0, 63)), AW'($urandom), AW'($urandom), 1'($urandom),
        AW'($urandom_range(0, 63)), HW'($urandom), 1'($urandom), 1'($urandom),
        1'($urandom));
  endtask

  // Idle cycle that only predicts at pc.
  task automatic pred_only(input logic [AW-1:0] pc);
    cyc(1'b0, pc, 32'h100, 32'h2000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_ready = 0; m_sweep = NUM; m_ghr = 0;
    RST = 1'b1; PC_IN_PRED = '0; SKIP_OFF_IN = '0; TAKE_OFF_IN = '0; PRED_EN = 1'b0;
    PC_IN_RES = '0; HIST_IN_RES = '0; TAKE_IN = 1'b0; WE = 1'b0; MISPRED_IN = 1'b0;
    @(posedge CLK); #1;

    // Reset, full sweep with ignored random traffic, then read every entry.
    cyc(1'b1, 32'h4, 32'h4, 32'h40, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (NUM + 2) rnd(0);
    for (int i = 0; i < NUM; i++) pred_only(AW'(i));

    // Reset again, interrupt the sweep at ptr 7, restart.
    cyc(1'b1, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (7) rnd(0);
    cyc(1'b1, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (NUM + 1) rnd(0);

    // Fresh table for directed cases.
    cyc(1'b1, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (NUM) pred_only('0);

    // Same-cycle update and predict on index 5: no bypass.
    cyc(1'b0, 32'h5, 32'h8, 32'h80, 1'b0, 32'h5, '0, 1'b1, 1'b1, 1'b0);
    pred_only(32'h5);

    // Saturation at PC 0x4: up three times, then down four times.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 32'h4, 32'h8, 32'h80, 1'b0, 32'h4, '0, 1'b1, 1'b1, 1'b0);
    pred_only(32'h4);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 32'h4, 32'h8, 32'h80, 1'b0, 32'h4, '0, 1'b0, 1'b1, 1'b0);
    pred_only(32'h4);

    // History building: consumed predictions on PC 0x10, then repair
    // colliding with a consumed prediction.
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 32'h10, 32'h4, 32'h100, 1'b1, 32'h10, 4'b0000, 1'b1, 1'b1, 1'b0);
    pred_only(32'h10);
    cyc(1'b0, 32'h10, 32'h4, 32'h100, 1'b1, 32'h3, 4'b1010, 1'b0, 1'b1, 1'b1);
    pred_only(32'h10);
    // Mispredict without WE must be ignored.
    cyc(1'b0, 32'h10, 32'h4, 32'h100, 1'b0, 32'h3, 4'b1111, 1'b1, 1'b0, 1'b1);
    pred_only(32'h10);

    // Random traffic with occasional reset.
    repeat (2000) rnd(400);
    repeat (NUM + 2) rnd(0);

    @(negedge CLK); #1;
    check("scoreboard_drained", AW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
